uart_rx_16x: RTL

- 8-bit, LSB-first, 8N1 UART receiver paired with the existing transmitter in the audio codec's serial link.
- Oversamples the asynchronous rxd line with a baud-rate strobe (OVERSAMPLE x bit rate) and samples each bit at mid-bit.
- Presents received bytes in a holding register with a ready/rd handshake, plus framing-error and overrun status.
- Exposes state on CS for debug, matching the transmitter.

---
 rtl/uart_rx_16x.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_16x.sv
// 8N1 LSB-first UART receiver. Oversamples rxd with a baud strobe and samples each bit at mid-bit.
// Received bytes wait in a holding register behind a ready/rd handshake, with sticky error flags.
module uart_rx_16x #(
  parameter int OVERSAMPLE = 16,
  parameter int SCW        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       sample,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] CS
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_e;

  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE/2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  state_e         state_q, state_d;
  logic           meta_q, rxs_q;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     dout_q, dout_d;
  logic           ready_q, ready_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q  <= rxd;
      rxs_q   <= meta_q;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Host read clears first; a flag set below in the same cycle overrides it.
    if (rd) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sample && !rxs_q) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (sample) begin
          scnt_d = scnt_q + SCW'(1);
          if (scnt_q == SC_MID) begin
            if (!rxs_q) begin
              state_d = DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (sample) begin
          scnt_d = scnt_q + SCW'(1);
          if (scnt_q == SC_LAST) begin
            shift_d = {rxs_q, shift_q[7:1]};
            scnt_d  = '0;
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          scnt_d = scnt_q + SCW'(1);
          if (scnt_q == SC_LAST) begin
            scnt_d = '0;
            if (rxs_q) begin
              state_d = IDLE;
              if (!ready_q || rd) begin
                dout_d  = shift_q;
                ready_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end
        end
      end
      // Hold here until the line returns high so a break cannot look like a new start.
      BRK: begin
        if (sample && rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign CS        = state_q;

endmodule
